// File: rtl/fifo_read_ctrl_if.sv
// rtl/fifo_read_ctrl_if.sv - read-side handshake/status bundle of the async FIFO
//
// Purpose: groups the consumer pop request, the incoming write-domain Gray
//          pointer and every read-side output of fifo_read_ctrl.
// Modports:
//   slave  - the read controller (receives rinc/wptr_gray, drives the rest)
//   master - the consumer / environment side
interface fifo_read_ctrl_if #(
  parameter int ADDRESS_SIZE = 5
);
  logic                    rinc;
  logic [ADDRESS_SIZE:0]   wptr_gray;
  logic                    read;
  logic [ADDRESS_SIZE-1:0] radrs;
  logic                    rvalid;
  logic [ADDRESS_SIZE:0]   rptr_gray;
  logic                    rempty;
  logic                    ralmost_empty;
  logic [ADDRESS_SIZE:0]   rlevel;
  logic                    runderflow;

  modport slave (
    input  rinc, wptr_gray,
    output read, radrs, rvalid, rptr_gray, rempty, ralmost_empty, rlevel, runderflow
  );

  modport master (
    output rinc, wptr_gray,
    input  read, radrs, rvalid, rptr_gray, rempty, ralmost_empty, rlevel, runderflow
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - async FIFO read-domain pointer, sync and status controller
//
// Purpose: keeps the binary/Gray read pointer, synchronises the write Gray
//          pointer into rclk, drives the memory read port and produces
//          empty / almost-empty / level / sticky underflow status.
// Ports:
//   rclk    - read clock
//   rrst_n  - async active-low reset
//   bus     - fifo_read_ctrl_if.slave:
//             rinc (pop), wptr_gray (unsynchronised write Gray pointer),
//             read/radrs (memory read port), rvalid (rdata valid),
//             rptr_gray (to write domain), rempty, ralmost_empty,
//             rlevel, runderflow
module fifo_read_ctrl #(
  parameter int ADDRESS_SIZE = 5,
  parameter int AE_THRESH    = 2
) (
  input  logic           rclk,
  input  logic           rrst_n,
  fifo_read_ctrl_if.slave bus
);
  localparam int PTR_W = ADDRESS_SIZE + 1;

  logic [PTR_W-1:0] r_rbin;
  logic [PTR_W-1:0] r_rptr_gray;
  logic [PTR_W-1:0] r_rq1;
  logic [PTR_W-1:0] r_rq2;
  logic             r_rempty;
  logic             r_ralmost_empty;
  logic [PTR_W-1:0] r_rlevel;
  logic             r_rvalid;
  logic             r_runderflow;

  logic             w_read;
  logic [PTR_W-1:0] w_rbin_next;
  logic [PTR_W-1:0] w_rgray_next;
  logic [PTR_W-1:0] w_wbin_s;
  logic [PTR_W-1:0] w_diff;

  // A pop is only honoured when not empty, so the pointer can never overrun.
  assign w_read       = bus.rinc & ~r_rempty;
  assign w_rbin_next  = r_rbin + PTR_W'(w_read);
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wbin_s = '0;
    for (int i = 0; i < PTR_W; i++) begin
      w_wbin_s[i] = ^(r_rq2 >> i);
    end
  end

  // Modular difference; MSB wrap bit makes a full FIFO read as 2**ADDRESS_SIZE.
  assign w_diff = w_wbin_s - w_rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin          <= '0;
      r_rptr_gray     <= '0;
      r_rq1           <= '0;
      r_rq2           <= '0;
      r_rempty        <= 1'b1;
      r_ralmost_empty <= 1'b1;
      r_rlevel        <= '0;
      r_rvalid        <= 1'b0;
      r_runderflow    <= 1'b0;
    end else begin
      r_rq1           <= bus.wptr_gray;
      r_rq2           <= r_rq1;
      r_rbin          <= w_rbin_next;
      r_rptr_gray     <= w_rgray_next;
      // Compared against the stale synchronised pointer: may report empty late,
      // never non-empty early.
      r_rempty        <= (w_rgray_next == r_rq2);
      r_rlevel        <= w_diff;
      r_ralmost_empty <= (w_diff <= PTR_W'(AE_THRESH));
      r_rvalid        <= w_read;
      r_runderflow    <= r_runderflow | (bus.rinc & r_rempty);
    end
  end

  assign bus.read          = w_read;
  assign bus.radrs         = r_rbin[ADDRESS_SIZE-1:0];
  assign bus.rvalid        = r_rvalid;
  assign bus.rptr_gray     = r_rptr_gray;
  assign bus.rempty        = r_rempty;
  assign bus.ralmost_empty = r_ralmost_empty;
  assign bus.rlevel        = r_rlevel;
  assign bus.runderflow    = r_runderflow;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - directed self-checking bench for fifo_read_ctrl
module tb_fifo_read_ctrl;
  logic rclk;
  logic rrst_n;
  int   checks;
  int   failures;

  fifo_read_ctrl_if #(.ADDRESS_SIZE(5)) bus ();

  fifo_read_ctrl #(.ADDRESS_SIZE(5), .AE_THRESH(2)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [5:0] to_gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    bus.rinc = 1'b0;
    bus.wptr_gray = 6'd0;
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge rclk);
    bus.rinc = 1'b1;
    bus.wptr_gray = 6'd0;
    rrst_n = 1'b0;
    #1;
    checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL reset_rempty got=%0b exp=1", bus.rempty); end
    checks++; if (bus.read !== 1'b0) begin failures++; $display("FAIL reset_read got=%0b exp=0", bus.read); end
    checks++; if (bus.rlevel !== 6'd0) begin failures++; $display("FAIL reset_rlevel got=%0d exp=0", bus.rlevel); end
    checks++; if (bus.rptr_gray !== 6'd0) begin failures++; $display("FAIL reset_rptr_gray got=%0h exp=0", bus.rptr_gray); end
    checks++; if (bus.runderflow !== 1'b0) begin failures++; $display("FAIL reset_runderflow got=%0b exp=0", bus.runderflow); end
    checks++; if (bus.ralmost_empty !== 1'b1) begin failures++; $display("FAIL reset_ralmost_empty got=%0b exp=1", bus.ralmost_empty); end
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0b exp=0", bus.rvalid); end
    @(negedge rclk);
    bus.rinc = 1'b0;
    rrst_n = 1'b1;
  endtask

  task automatic test_sync_single();
    @(negedge rclk);
    bus.wptr_gray = 6'd1;
    @(negedge rclk);
    checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL sync_edge1_rempty got=%0b exp=1", bus.rempty); end
    @(negedge rclk);
    checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL sync_edge2_rempty got=%0b exp=1", bus.rempty); end
    @(negedge rclk);
    checks++; if (bus.rempty !== 1'b0) begin failures++; $display("FAIL sync_edge3_rempty got=%0b exp=0", bus.rempty); end
    checks++; if (bus.rlevel !== 6'd1) begin failures++; $display("FAIL sync_rlevel got=%0d exp=1", bus.rlevel); end
    bus.rinc = 1'b1;
    #1;
    checks++; if (bus.read !== 1'b1) begin failures++; $display("FAIL pop_read got=%0b exp=1", bus.read); end
    checks++; if (bus.radrs !== 5'd0) begin failures++; $display("FAIL pop_radrs got=%0d exp=0", bus.radrs); end
    @(negedge rclk);
    bus.rinc = 1'b0;
    checks++; if (bus.rvalid !== 1'b1) begin failures++; $display("FAIL pop_rvalid got=%0b exp=1", bus.rvalid); end
    checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL pop_rempty got=%0b exp=1", bus.rempty); end
    checks++; if (bus.rptr_gray !== 6'd1) begin failures++; $display("FAIL pop_rptr_gray got=%0h exp=1", bus.rptr_gray); end
    @(negedge rclk);
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL pop_rvalid_clear got=%0b exp=0", bus.rvalid); end
  endtask

  task automatic test_full_drain();
    do_reset();
    bus.wptr_gray = 6'h30;
    repeat (3) @(negedge rclk);
    checks++; if (bus.rempty !== 1'b0) begin failures++; $display("FAIL full_rempty got=%0b exp=0", bus.rempty); end
    bus.rinc = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++; if (bus.radrs !== 5'(i)) begin failures++; $display("FAIL drain_radrs i=%0d got=%0d exp=%0d", i, bus.radrs, i); end
      checks++; if (bus.rlevel !== 6'(32 - i)) begin failures++; $display("FAIL drain_rlevel i=%0d got=%0d exp=%0d", i, bus.rlevel, 32 - i); end
      checks++; if (bus.ralmost_empty !== ((32 - i) <= 2)) begin failures++; $display("FAIL drain_ralmost_empty i=%0d got=%0b exp=%0b", i, bus.ralmost_empty, ((32 - i) <= 2)); end
      checks++; if (bus.read !== 1'b1) begin failures++; $display("FAIL drain_read i=%0d got=%0b exp=1", i, bus.read); end
      @(negedge rclk);
    end
    bus.rinc = 1'b0;
    checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL drained_rempty got=%0b exp=1", bus.rempty); end
    checks++; if (bus.rlevel !== 6'd0) begin failures++; $display("FAIL drained_rlevel got=%0d exp=0", bus.rlevel); end
    checks++; if (bus.ralmost_empty !== 1'b1) begin failures++; $display("FAIL drained_ralmost_empty got=%0b exp=1", bus.ralmost_empty); end
    checks++; if (bus.rptr_gray !== 6'h30) begin failures++; $display("FAIL drained_rptr_gray got=%0h exp=30", bus.rptr_gray); end
  endtask

  task automatic test_underflow();
    @(negedge rclk);
    bus.rinc = 1'b1;
    #1;
    checks++; if (bus.read !== 1'b0) begin failures++; $display("FAIL uflow_read got=%0b exp=0", bus.read); end
    @(negedge rclk);
    bus.rinc = 1'b0;
    checks++; if (bus.runderflow !== 1'b1) begin failures++; $display("FAIL uflow_set got=%0b exp=1", bus.runderflow); end
    checks++; if (bus.rptr_gray !== 6'h30) begin failures++; $display("FAIL uflow_rptr_gray got=%0h exp=30", bus.rptr_gray); end
    checks++; if (bus.radrs !== 5'd0) begin failures++; $display("FAIL uflow_radrs got=%0d exp=0", bus.radrs); end
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL uflow_rvalid got=%0b exp=0", bus.rvalid); end
    repeat (3) @(negedge rclk);
    checks++; if (bus.runderflow !== 1'b1) begin failures++; $display("FAIL uflow_sticky got=%0b exp=1", bus.runderflow); end
    do_reset();
    #1;
    checks++; if (bus.runderflow !== 1'b0) begin failures++; $display("FAIL uflow_cleared got=%0b exp=0", bus.runderflow); end
  endtask

  task automatic test_wrap();
    logic [5:0] wb;
    logic [5:0] rb;
    do_reset();
    wb = 6'd0;
    rb = 6'd0;
    for (int n = 0; n < 70; n++) begin
      wb = wb + 6'd1;
      bus.wptr_gray = to_gray(wb);
      @(negedge rclk);
      @(negedge rclk);
      checks++; if (bus.rempty !== 1'b1 || bus.rlevel !== 6'd0) begin failures++; $display("FAIL wrap_early n=%0d rempty=%0b rlevel=%0d exp rempty=1 rlevel=0", n, bus.rempty, bus.rlevel); end
      @(negedge rclk);
      checks++; if (bus.rempty !== 1'b0 || bus.rlevel !== 6'd1) begin failures++; $display("FAIL wrap_fill n=%0d rempty=%0b rlevel=%0d exp rempty=0 rlevel=1", n, bus.rempty, bus.rlevel); end
      bus.rinc = 1'b1;
      #1;
      checks++; if (bus.radrs !== rb[4:0]) begin failures++; $display("FAIL wrap_radrs n=%0d got=%0d exp=%0d", n, bus.radrs, rb[4:0]); end
      @(negedge rclk);
      bus.rinc = 1'b0;
      rb = rb + 6'd1;
      checks++; if (bus.rempty !== 1'b1 || bus.rlevel !== 6'd0) begin failures++; $display("FAIL wrap_drain n=%0d rempty=%0b rlevel=%0d exp rempty=1 rlevel=0", n, bus.rempty, bus.rlevel); end
    end
    checks++; if (bus.rptr_gray !== 6'h05) begin failures++; $display("FAIL wrap_rptr_gray got=%0h exp=05", bus.rptr_gray); end
    checks++; if (bus.runderflow !== 1'b0) begin failures++; $display("FAIL wrap_runderflow got=%0b exp=0", bus.runderflow); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.wptr_gray = to_gray(6'd8);
    repeat (3) @(negedge rclk);
    bus.rinc = 1'b1;
    repeat (3) @(posedge rclk);
    #2;
    checks++; if (bus.rvalid !== 1'b1) begin failures++; $display("FAIL mid_pre_rvalid got=%0b exp=1", bus.rvalid); end
    rrst_n = 1'b0;
    bus.wptr_gray = 6'd0;
    #1;
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid got=%0b exp=0", bus.rvalid); end
    checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL mid_rempty got=%0b exp=1", bus.rempty); end
    checks++; if (bus.rlevel !== 6'd0) begin failures++; $display("FAIL mid_rlevel got=%0d exp=0", bus.rlevel); end
    checks++; if (bus.rptr_gray !== 6'd0) begin failures++; $display("FAIL mid_rptr_gray got=%0h exp=0", bus.rptr_gray); end
    checks++; if (bus.radrs !== 5'd0) begin failures++; $display("FAIL mid_radrs got=%0d exp=0", bus.radrs); end
    checks++; if (bus.read !== 1'b0) begin failures++; $display("FAIL mid_read got=%0b exp=0", bus.read); end
    checks++; if (bus.ralmost_empty !== 1'b1) begin failures++; $display("FAIL mid_ralmost_empty got=%0b exp=1", bus.ralmost_empty); end
    @(negedge rclk);
    bus.rinc = 1'b0;
    rrst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge rclk);
      checks++; if (bus.rvalid !== 1'b0 || bus.rempty !== 1'b1) begin failures++; $display("FAIL mid_after k=%0d rvalid=%0b rempty=%0b exp rvalid=0 rempty=1", k, bus.rvalid, bus.rempty); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rrst_n = 1'b0;
    bus.rinc = 1'b0;
    bus.wptr_gray = 6'd0;
    test_reset();
    test_sync_single();
    test_full_drain();
    test_underflow();
    test_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
